// File: rtl/ocl_inst_issue_queue_pkg.sv
// Shared widths and the packed instruction-entry layout for the OCL issue queue.
// Entries are stored and issued as a single packed word.
package ocl_inst_issue_queue_pkg;

   localparam int OPCODE_WIDTH  = 6;
   localparam int INTT_ID_WIDTH = 6;
   localparam int LWE_BIT_WIDTH = 32;
   localparam int GATE_WIDTH    = 3;
   localparam int SUBS_WIDTH    = 4;

   typedef struct packed {
      logic [OPCODE_WIDTH-1:0]  opcode;
      logic [GATE_WIDTH-1:0]    gate;
      logic [INTT_ID_WIDTH-1:0] intt_id;
      logic [LWE_BIT_WIDTH-1:0] init_value;
      logic [SUBS_WIDTH-1:0]    subs_factor;
   } inst_entry_t;

   localparam int INST_ENTRY_WIDTH = $bits(inst_entry_t);

   function automatic inst_entry_t pack_entry(
      input logic [OPCODE_WIDTH-1:0]  opcode,
      input logic [GATE_WIDTH-1:0]    gate,
      input logic [INTT_ID_WIDTH-1:0] intt_id,
      input logic [LWE_BIT_WIDTH-1:0] init_value,
      input logic [SUBS_WIDTH-1:0]    subs_factor
   );
      inst_entry_t e;
      e.opcode      = opcode;
      e.gate        = gate;
      e.intt_id     = intt_id;
      e.init_value  = init_value;
      e.subs_factor = subs_factor;
      return e;
   endfunction

endpackage

// File: rtl/ocl_inst_issue_queue_credit_counter.sv
// Saturating ROB credit counter: issue consumes a credit, retire returns one.
// A retire arriving with all credits already home is ignored and latched as an underflow.
module issue_credit_counter #(
   parameter int ROB_DEPTH = 8,
   parameter int CRED_W    = $clog2(ROB_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dec_i,
   input  logic              inc_i,
   output logic [CRED_W-1:0] credits_o,
   output logic              underflow_o
);

   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(ROB_DEPTH);

   logic [CRED_W-1:0] credits_q, credits_d;
   logic              underflow_q, underflow_d;
   logic              at_max, at_zero, inc_ok, dec_ok;

   assign at_max  = (credits_q == CRED_MAX);
   assign at_zero = (credits_q == '0);
   assign inc_ok  = inc_i && !at_max;
   assign dec_ok  = dec_i && !at_zero;

   always_comb begin
      credits_d   = credits_q;
      underflow_d = underflow_q | (inc_i && at_max);
      unique case ({inc_ok, dec_ok})
         2'b10:   credits_d = credits_q + CRED_W'(1);
         2'b01:   credits_d = credits_q - CRED_W'(1);
         default: credits_d = credits_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credits_q   <= CRED_MAX;
         underflow_q <= 1'b0;
      end else begin
         credits_q   <= credits_d;
         underflow_q <= underflow_d;
      end
   end

   assign credits_o   = credits_q;
   assign underflow_o = underflow_q;

endmodule

// File: rtl/ocl_inst_issue_queue.sv
// Instruction FIFO between the OCL slave and the compute-chain ROB input pipe.
// Issue is gated by ROB credits so the ROB cannot overflow regardless of pipe depth.
module ocl_inst_issue_queue
   import ocl_inst_issue_queue_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3,
   parameter int ROB_DEPTH  = 8,
   parameter int CRED_W     = $clog2(ROB_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inst_wr_en,
   input  logic [OPCODE_WIDTH-1:0]  inst_opcode,
   input  logic [GATE_WIDTH-1:0]    inst_gate,
   input  logic [INTT_ID_WIDTH-1:0] inst_iNTT_id,
   input  logic [LWE_BIT_WIDTH-1:0] inst_init_value,
   input  logic [SUBS_WIDTH-1:0]    inst_subs_factor,
   output logic                     inst_full,
   output logic                     inst_empty,
   input  logic                     issue_enable,
   input  logic                     flush,
   input  logic                     rob_retire,
   output logic                     rob_wr_en,
   output logic [OPCODE_WIDTH-1:0]  rob_opcode,
   output logic [GATE_WIDTH-1:0]    rob_gate,
   output logic [INTT_ID_WIDTH-1:0] rob_iNTT_id,
   output logic [LWE_BIT_WIDTH-1:0] rob_init_value,
   output logic [SUBS_WIDTH-1:0]    rob_subs_factor,
   output logic [DEPTH_LOG2:0]      occupancy,
   output logic [CRED_W-1:0]        credits,
   output logic                     err_overflow,
   output logic                     err_underflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PTR_W = DEPTH_LOG2 + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   inst_entry_t      mem_q [DEPTH];
   inst_entry_t      wr_entry, head_entry;
   inst_entry_t      payload_q, payload_d;
   logic             rob_wr_en_q, rob_wr_en_d;
   logic             err_overflow_q, err_overflow_d;
   logic             full, empty, push, do_issue;
   logic [CRED_W-1:0] credit_cnt;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                  (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

   assign wr_entry   = pack_entry(inst_opcode, inst_gate, inst_iNTT_id,
                                  inst_init_value, inst_subs_factor);
   assign head_entry = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

   // Fullness is judged on the registered pointers only; a pop this cycle never frees room.
   assign push     = inst_wr_en && !full && !flush;
   assign do_issue = !empty && (credit_cnt != '0) && issue_enable && !flush;

   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      rob_wr_en_d    = do_issue;
      payload_d      = payload_q;
      err_overflow_d = err_overflow_q | (inst_wr_en && full && !flush);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_issue)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_issue)
         payload_d = head_entry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         rob_wr_en_q    <= 1'b0;
         payload_q      <= '0;
         err_overflow_q <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         rob_wr_en_q    <= rob_wr_en_d;
         payload_q      <= payload_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   // Storage needs no reset: the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_entry;
   end

   issue_credit_counter #(
      .ROB_DEPTH (ROB_DEPTH),
      .CRED_W    (CRED_W)
   ) u_credit (
      .clk         (clk),
      .rst         (rst),
      .dec_i       (do_issue),
      .inc_i       (rob_retire),
      .credits_o   (credit_cnt),
      .underflow_o (err_underflow)
   );

   assign inst_full       = full;
   assign inst_empty      = empty;
   assign occupancy       = wr_ptr_q - rd_ptr_q;
   assign credits         = credit_cnt;
   assign err_overflow    = err_overflow_q;
   assign rob_wr_en       = rob_wr_en_q;
   assign rob_opcode      = payload_q.opcode;
   assign rob_gate        = payload_q.gate;
   assign rob_iNTT_id     = payload_q.intt_id;
   assign rob_init_value  = payload_q.init_value;
   assign rob_subs_factor = payload_q.subs_factor;

endmodule

// File: tb/tb_ocl_inst_issue_queue.sv
// Directed, table-driven bench for ocl_inst_issue_queue: one vector per clock edge,
// plus a hand-written push-to-issue latency sequence.
module tb_ocl_inst_issue_queue;
   import ocl_inst_issue_queue_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     inst_wr_en = 1'b0;
   logic [OPCODE_WIDTH-1:0]  inst_opcode = '0;
   logic [GATE_WIDTH-1:0]    inst_gate = '0;
   logic [INTT_ID_WIDTH-1:0] inst_iNTT_id = '0;
   logic [LWE_BIT_WIDTH-1:0] inst_init_value = '0;
   logic [SUBS_WIDTH-1:0]    inst_subs_factor = '0;
   logic                     issue_enable = 1'b0;
   logic                     flush = 1'b0;
   logic                     rob_retire = 1'b0;
   logic                     inst_full, inst_empty, rob_wr_en;
   logic [OPCODE_WIDTH-1:0]  rob_opcode;
   logic [GATE_WIDTH-1:0]    rob_gate;
   logic [INTT_ID_WIDTH-1:0] rob_iNTT_id;
   logic [LWE_BIT_WIDTH-1:0] rob_init_value;
   logic [SUBS_WIDTH-1:0]    rob_subs_factor;
   logic [3:0]               occupancy;
   logic [3:0]               credits;
   logic                     err_overflow, err_underflow;

   always #5 clk = ~clk;

   ocl_inst_issue_queue #(.DEPTH_LOG2(3), .ROB_DEPTH(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .inst_wr_en       (inst_wr_en),
      .inst_opcode      (inst_opcode),
      .inst_gate        (inst_gate),
      .inst_iNTT_id     (inst_iNTT_id),
      .inst_init_value  (inst_init_value),
      .inst_subs_factor (inst_subs_factor),
      .inst_full        (inst_full),
      .inst_empty       (inst_empty),
      .issue_enable     (issue_enable),
      .flush            (flush),
      .rob_retire       (rob_retire),
      .rob_wr_en        (rob_wr_en),
      .rob_opcode       (rob_opcode),
      .rob_gate         (rob_gate),
      .rob_iNTT_id      (rob_iNTT_id),
      .rob_init_value   (rob_init_value),
      .rob_subs_factor  (rob_subs_factor),
      .occupancy        (occupancy),
      .credits          (credits),
      .err_overflow     (err_overflow),
      .err_underflow    (err_underflow)
   );

   typedef struct {
      logic       r, w, ie, fl, ret;
      logic [5:0] op;
      logic       ewr;
      logic [5:0] eop;
      logic [3:0] eocc, ecred;
      logic       eemp, efull, eov, eun;
   } vec_t;

   vec_t vecs[$];
   int   passed = 0;
   int   total  = 0;

   // Every other payload field is derived from the opcode so one number identifies an entry.
   function automatic logic [2:0] gate_of(input logic [5:0] op);
      return op[2:0];
   endfunction
   function automatic logic [5:0] intt_of(input logic [5:0] op);
      return {op[2:0], op[5:3]};
   endfunction
   function automatic logic [31:0] init_of(input logic [5:0] op);
      return 32'h0101_0101 * {26'd0, op};
   endfunction
   function automatic logic [3:0] subs_of(input logic [5:0] op);
      return op[3:0];
   endfunction

   task automatic add(input logic r, input logic w, input logic [5:0] op, input logic ie,
                      input logic fl, input logic ret, input logic ewr, input logic [5:0] eop,
                      input int occ, input int cred, input logic emp, input logic full,
                      input logic ov, input logic un);
      vec_t v;
      v.r = r; v.w = w; v.op = op; v.ie = ie; v.fl = fl; v.ret = ret;
      v.ewr = ewr; v.eop = eop; v.eocc = 4'(occ); v.ecred = 4'(cred);
      v.eemp = emp; v.efull = full; v.eov = ov; v.eun = un;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
   endtask

   task automatic drive(input logic r, input logic w, input logic [5:0] op, input logic ie,
                        input logic fl, input logic ret);
      rst = r; inst_wr_en = w; inst_opcode = op; issue_enable = ie; flush = fl;
      rob_retire = ret;
      inst_gate = gate_of(op); inst_iNTT_id = intt_of(op);
      inst_init_value = init_of(op); inst_subs_factor = subs_of(op);
   endtask

   initial begin
      int lat;
      // reset
      add(1,0,0,0,0,0, 0,0,0,8,1,0,0,0);
      // three pushes issue in order, credits 8 -> 5
      add(0,1,6'h01,1,0,0, 0,0,1,8,0,0,0,0);
      add(0,1,6'h02,1,0,0, 1,6'h01,1,7,0,0,0,0);
      add(0,1,6'h03,1,0,0, 1,6'h02,1,6,0,0,0,0);
      add(0,0,0,1,0,0, 1,6'h03,0,5,1,0,0,0);
      add(0,0,0,1,0,0, 0,6'h03,0,5,1,0,0,0);
      for (int i = 0; i < 3; i++) add(0,0,0,1,0,1, 0,6'h03,0,6+i,1,0,0,0);
      // retire with all credits home
      add(0,0,0,1,0,1, 0,6'h03,0,8,1,0,0,1);
      // ten pushes with issue held off: two dropped as overflow
      for (int i = 0; i < 8; i++) add(0,1,6'(16+i),0,0,0, 0,6'h03,i+1,8,0,(i==7),0,1);
      for (int i = 0; i < 2; i++) add(0,1,6'(24+i),0,0,0, 0,6'h03,8,8,0,1,1,1);
      for (int i = 0; i < 8; i++) add(0,0,0,1,0,0, 1,6'(16+i),7-i,7-i,(i==7),0,1,1);
      add(0,0,0,1,0,0, 0,6'h17,0,0,1,0,1,1);
      // zero credits, two queued, one retire releases exactly one issue
      add(0,1,6'h20,1,0,0, 0,6'h17,1,0,0,0,1,1);
      add(0,1,6'h21,1,0,0, 0,6'h17,2,0,0,0,1,1);
      add(0,0,0,1,0,1, 0,6'h17,2,1,0,0,1,1);
      add(0,0,0,1,0,0, 1,6'h20,1,0,0,0,1,1);
      add(0,0,0,1,0,0, 0,6'h20,1,0,0,0,1,1);
      // simultaneous retire and issue at credits 1
      add(0,0,0,1,0,1, 0,6'h20,1,1,0,0,1,1);
      add(0,0,0,1,0,1, 1,6'h21,0,1,1,0,1,1);
      // reset clears errors
      add(1,0,0,0,0,0, 0,0,0,8,1,0,0,0);
      // flush with same-cycle push
      for (int i = 0; i < 5; i++) add(0,1,6'(48+i),0,0,0, 0,0,i+1,8,0,0,0,0);
      add(0,1,6'h35,0,1,0, 0,0,0,8,1,0,0,0);
      // flush suppresses issue even with issue enabled
      add(0,1,6'h36,0,0,0, 0,0,1,8,0,0,0,0);
      add(0,0,0,1,1,0, 0,0,0,8,1,0,0,0);
      // reset with 4 queued and credits 2
      for (int i = 0; i < 6; i++) add(0,1,6'(64+i),0,0,0, 0,0,i+1,8,0,0,0,0);
      for (int i = 0; i < 6; i++) add(0,0,0,1,0,0, 1,6'(64+i),5-i,7-i,(i==5),0,0,0);
      for (int i = 0; i < 4; i++) add(0,1,6'(70+i),0,0,0, 0,6'h45,i+1,2,0,0,0,0);
      add(1,1,6'h4A,1,0,1, 0,0,0,8,1,0,0,0);
      for (int i = 0; i < 2; i++) add(0,0,0,1,0,0, 0,0,0,8,1,0,0,0);

      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k].r, vecs[k].w, vecs[k].op, vecs[k].ie, vecs[k].fl, vecs[k].ret);
         @(posedge clk);
         #1;
         chk("rob_wr_en",  k, 64'(rob_wr_en),       64'(vecs[k].ewr));
         chk("rob_opcode", k, 64'(rob_opcode),      64'(vecs[k].eop));
         chk("rob_gate",   k, 64'(rob_gate),        64'(gate_of(vecs[k].eop)));
         chk("rob_intt",   k, 64'(rob_iNTT_id),     64'(intt_of(vecs[k].eop)));
         chk("rob_init",   k, 64'(rob_init_value),  64'(init_of(vecs[k].eop)));
         chk("rob_subs",   k, 64'(rob_subs_factor), 64'(subs_of(vecs[k].eop)));
         chk("occupancy",  k, 64'(occupancy),       64'(vecs[k].eocc));
         chk("credits",    k, 64'(credits),         64'(vecs[k].ecred));
         chk("empty",      k, 64'(inst_empty),      64'(vecs[k].eemp));
         chk("full",       k, 64'(inst_full),       64'(vecs[k].efull));
         chk("err_ovf",    k, 64'(err_overflow),    64'(vecs[k].eov));
         chk("err_udf",    k, 64'(err_underflow),   64'(vecs[k].eun));
         $display("vec %0d: rst=%0b wr=%0b op=%0h ie=%0b fl=%0b ret=%0b -> rob_wr=%0b op=%0h occ=%0d cred=%0d",
                  k, vecs[k].r, vecs[k].w, vecs[k].op, vecs[k].ie, vecs[k].fl, vecs[k].ret,
                  rob_wr_en, rob_opcode, occupancy, credits);
      end

      // Latency: push at one edge, entry visible after it, issue strobe after the next.
      drive(0, 1, 6'h3F, 1, 0, 0);
      @(posedge clk);
      #1;
      drive(0, 0, 6'h00, 1, 0, 0);
      chk("lat_no_early_wr", 0, 64'(rob_wr_en), 64'(1'b0));
      lat = 1;
      while (!rob_wr_en && lat < 6) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("lat_edges",  0, 64'(lat),        64'(2));
      chk("lat_opcode", 0, 64'(rob_opcode), 64'(6'h3F));
      chk("lat_credits",0, 64'(credits),    64'(7));
      $display("latency: push-to-issue edges=%0d op=%0h", lat, rob_opcode);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
